// File: rtl/camlink_rx_pkg.sv
// Shared definitions for the CameraLink receive path: framer states, FIFO entry layout
// and counter width.
package camlink_rx_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } framer_state_t;

    // A FIFO entry is packed as {tuser, tlast, data}.
    function automatic int fifo_entry_width(input int data_width);
        return data_width + 2;
    endfunction

endpackage

// File: rtl/camlink_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Full when count reaches DEPTH.
// The read port is show-ahead: rd_data is the current head.
module camlink_sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // A push while full is only issued together with a pop, so the slot is free.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/camlink_axis_framer.sv
// CameraLink FVAL/LVAL/DVAL to AXI4-Stream framer with overflow drop and frame counters.
// Define CAMLINK_LINE_CHECK_EN to compile in the per-line beat count check.
//
// state  | meaning
// WAIT   | between frames; waits for FVAL rise with cfg_enable set
// ACTIVE | forwarding beats of the current frame
// DROP   | frame truncated by overflow; discard until the next FVAL rise
import camlink_rx_pkg::*;

module camlink_axis_framer #(
    parameter  int TAPS       = 3,
    parameter  int TAP_WIDTH  = 8,
    parameter  int DEPTH      = 16,
    localparam int DATA_WIDTH = TAPS * TAP_WIDTH
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  cam_fval,
    input  logic                  cam_lval,
    input  logic                  cam_dval,
    input  logic [DATA_WIDTH-1:0] cam_data,
    input  logic                  cfg_enable,
    input  logic [CNT_W-1:0]      cfg_line_len,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  overflow,
    output logic                  line_err,
    output logic [CNT_W-1:0]      frame_count,
    output logic [CNT_W-1:0]      drop_count
);
    localparam int EW = fifo_entry_width(DATA_WIDTH);

    logic                  fval_r, fval_rr, lval_r, lval_rr, dval_r;
    logic [DATA_WIDTH-1:0] data_r;

    // FVAL history resets high so a frame already running at reset release is never seen as a rise.
    always_ff @(posedge aclk) begin
        if (rst) begin
            fval_r  <= 1'b1;
            fval_rr <= 1'b1;
            lval_r  <= 1'b0;
            lval_rr <= 1'b0;
            dval_r  <= 1'b0;
            data_r  <= '0;
        end else begin
            fval_r  <= cam_fval;
            fval_rr <= fval_r;
            lval_r  <= cam_lval;
            lval_rr <= lval_r;
            dval_r  <= cam_dval;
            data_r  <= cam_data;
        end
    end

    logic fval_rise, fval_fall, lval_fall, line_beat;
    assign fval_rise = fval_r & ~fval_rr;
    assign fval_fall = ~fval_r & fval_rr;
    assign lval_fall = ~lval_r & lval_rr;
    assign line_beat = fval_r & lval_r & dval_r;

    framer_state_t         state, state_nx;
    logic                  start, beat, push_req, ovf, frame_done;
    logic                  stg_valid, stg_user, first_pend;
    logic [DATA_WIDTH-1:0] stg_data;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]         fifo_wdata, fifo_rdata;

    always_ff @(posedge aclk) begin
        if (rst) state <= WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        push_req   = 1'b0;
        ovf        = 1'b0;
        frame_done = 1'b0;
        case (state)
            WAIT: begin
                if (fval_rise && cfg_enable) begin
                    start    = 1'b1;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                push_req = stg_valid & (line_beat | lval_fall | fval_fall);
                ovf      = push_req & fifo_full & ~fifo_pop;
                if (ovf) begin
                    state_nx = DROP;
                end else if (fval_fall) begin
                    state_nx   = WAIT;
                    frame_done = 1'b1;
                end
            end
            DROP: begin
                if (fval_rise) begin
                    start    = cfg_enable;
                    state_nx = cfg_enable ? ACTIVE : WAIT;
                end
            end
            default: state_nx = WAIT;
        endcase
    end

    // A beat coinciding with the FVAL rise that starts the frame is kept.
    assign beat       = line_beat & ((state == ACTIVE) | start);
    assign fifo_push  = push_req & ~ovf;
    assign fifo_wdata = {stg_user, ~line_beat, stg_data};
    assign fifo_pop   = ~fifo_empty & (~m_axis_tvalid | m_axis_tready);

    always_ff @(posedge aclk) begin
        if (rst) begin
            stg_valid  <= 1'b0;
            stg_user   <= 1'b0;
            stg_data   <= '0;
            first_pend <= 1'b0;
        end else begin
            if (beat)       first_pend <= 1'b0;
            else if (start) first_pend <= 1'b1;

            if (state_nx != ACTIVE) begin
                stg_valid <= 1'b0;
            end else if (beat) begin
                stg_valid <= 1'b1;
                stg_user  <= first_pend | start;
                stg_data  <= data_r;
            end else if (lval_fall) begin
                stg_valid <= 1'b0;
            end
        end
    end

    camlink_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wdata),
        .pop     (fifo_pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge aclk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (~m_axis_tvalid | m_axis_tready) begin
            m_axis_tvalid <= ~fifo_empty;
            if (~fifo_empty) {m_axis_tuser, m_axis_tlast, m_axis_tdata} <= fifo_rdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            overflow    <= 1'b0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            overflow <= ovf;
            if (frame_done) frame_count <= frame_count + CNT_W'(1);
            if (ovf && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
        end
    end

`ifdef CAMLINK_LINE_CHECK_EN
    logic [CNT_W-1:0] beat_cnt;

    always_ff @(posedge aclk) begin
        if (rst) begin
            beat_cnt <= '0;
            line_err <= 1'b0;
        end else begin
            line_err <= lval_fall && (state == ACTIVE) && (cfg_line_len != '0)
                        && (beat_cnt != cfg_line_len);
            if (lval_fall)  beat_cnt <= '0;
            else if (beat)  beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_line_len;
    assign unused_line_len = ^cfg_line_len;
    assign line_err        = 1'b0;
`endif

endmodule
